// File: rtl/spifs_slave_shift.sv
// SPI slave shift engine: brings SCK/CS_N/MOSI into the clk_i domain and shifts
// words in all four SPI modes, fed by a single-entry transmit holding register.
module spifs_slave_shift #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_i,
  input  logic [4:0]        len_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              underrun_o,
  output logic              tip_o,
  input  logic              spi_clk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_in_i,
  output logic              spi_out_o,
  output logic              spi_oe_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   cpol_r, cpha_r, lsb_r;
  logic [5:0]             len_r, bit_cnt, tx_cnt;
  logic [DATA_W-1:0]      hold_q, tx_word, rx_sh;

  // Bit of a word presented as the k-th bit on the wire, 0 past the word end.
  function automatic logic tx_bit(input logic [DATA_W-1:0] word, input logic lsb,
                                  input logic [5:0] len, input logic [5:0] k);
    logic [5:0]        pos;
    logic [DATA_W-1:0] sh;
    pos = lsb ? k : 6'(len - 6'd1 - k);
    sh  = word >> pos;
    return (k < len) ? sh[0] : 1'b0;
  endfunction

  // Pin synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= (sck_sync << 1) | SYNC_STAGES'(spi_clk_i);
      cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(spi_cs_n_i);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_in_i);
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, lead, trail;
  logic enter, leave, sample_ev, shift_ev, word_done, load, wr, advance;
  logic [5:0]        len_eff_i, bit_next;
  logic [DATA_W-1:0] load_word, rx_next;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign lead      = cpol_r ? sck_fall : sck_rise;
  assign trail     = cpol_r ? sck_rise : sck_fall;

  assign enter     = (state == IDLE) & cs_d & ~cs_s;
  assign leave     = (state == ACTIVE) & ~cs_d & cs_s;
  assign sample_ev = (state == ACTIVE) & ~leave & (cpha_r ? trail : lead);
  assign shift_ev  = (state == ACTIVE) & ~leave & (cpha_r ? lead : trail);
  assign len_eff_i = (len_i == 5'd0) ? 6'd32 : {1'b0, len_i};
  assign bit_next  = bit_cnt + 6'd1;
  assign word_done = sample_ev & (bit_next == len_r);
  assign load      = enter | word_done;
  assign wr        = tx_valid_i & tx_ready_o;
  assign load_word = tx_ready_o ? '0 : hold_q;
  // Only move on once the bit on the wire has been sampled; this also holds the
  // first bit of a word through the first shift edge in either phase.
  assign advance   = shift_ev & (bit_cnt > tx_cnt);
  assign rx_next   = lsb_r ? (rx_sh | (DATA_W'(mosi_s) << bit_cnt))
                           : {rx_sh[DATA_W-2:0], mosi_s};

  assign tip_o    = (state == ACTIVE);
  assign spi_oe_o = tip_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      lsb_r      <= 1'b0;
      len_r      <= 6'd32;
      bit_cnt    <= '0;
      tx_cnt     <= '0;
      spi_out_o  <= 1'b0;
      tx_ready_o <= 1'b1;
      rx_valid_o <= 1'b0;
      underrun_o <= 1'b0;
      rx_data_o  <= '0;
    end else begin
      rx_valid_o <= 1'b0;
      underrun_o <= 1'b0;
      if (wr)        tx_ready_o <= 1'b0;
      else if (load) tx_ready_o <= 1'b1;
      if (load)      underrun_o <= tx_ready_o;
      case (state)
        IDLE: begin
          if (enter) begin
            state     <= ACTIVE;
            cpol_r    <= cpol_i;
            cpha_r    <= cpha_i;
            lsb_r     <= lsb_i;
            len_r     <= len_eff_i;
            bit_cnt   <= '0;
            tx_cnt    <= '0;
            spi_out_o <= tx_bit(load_word, lsb_i, len_eff_i, 6'd0);
          end
        end
        ACTIVE: begin
          if (leave) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_cnt    <= '0;
            spi_out_o <= 1'b0;
          end else begin
            if (word_done) begin
              bit_cnt    <= '0;
              tx_cnt     <= '0;
              rx_valid_o <= 1'b1;
              rx_data_o  <= rx_next;
              spi_out_o  <= tx_bit(load_word, lsb_r, len_r, 6'd0);
            end else if (sample_ev) begin
              bit_cnt <= bit_next;
            end
            if (advance) begin
              tx_cnt    <= tx_cnt + 6'd1;
              spi_out_o <= tx_bit(tx_word, lsb_r, len_r, tx_cnt + 6'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: holding register, word being transmitted, word being received.
  always_ff @(posedge clk_i) begin
    if (wr)   hold_q  <= tx_data_i;
    if (load) tx_word <= load_word;
    if (load)           rx_sh <= '0;
    else if (sample_ev) rx_sh <= rx_next;
  end

endmodule

// File: tb/tb_spifs_slave_shift.sv
// Bench for spifs_slave_shift: a behavioural SPI master drives words in all
// modes and the results are compared with expectations derived per word.
module tb_spifs_slave_shift;
  localparam int H = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cpol, cpha, lsb;
  logic [4:0]  len;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, underrun, tip;
  logic        spi_clk, spi_cs_n, spi_in, spi_out, spi_oe;

  always #5 clk = ~clk;

  spifs_slave_shift #(.DATA_W(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb),
    .len_i(len), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .underrun_o(underrun), .tip_o(tip), .spi_clk_i(spi_clk),
    .spi_cs_n_i(spi_cs_n), .spi_in_i(spi_in), .spi_out_o(spi_out),
    .spi_oe_o(spi_oe)
  );

  typedef struct {
    logic        cpol, cpha, lsb;
    logic [4:0]  len;
    logic        pre;
    logic [31:0] tx, mosi, exp_miso, exp_rx;
    int          exp_und;
  } vec_t;

  int          total = 0, bad = 0;
  int          rx_cnt = 0, und_cnt = 0;
  logic [31:0] rx_q[$];
  vec_t        vecs[11];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (underrun) und_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] last_rx(input int back);
    if (rx_q.size() > back) return rx_q[rx_q.size()-1-back];
    return 'x;
  endfunction

  function automatic vec_t mk_rand();
    vec_t        v;
    int          l;
    logic [31:0] mask;
    v.cpol = 1'($urandom_range(0, 1));
    v.cpha = 1'($urandom_range(0, 1));
    v.lsb  = 1'($urandom_range(0, 1));
    v.len  = 5'($urandom_range(0, 31));
    v.pre  = 1'($urandom_range(0, 1));
    v.tx   = $urandom;
    v.mosi = $urandom;
    l      = (v.len == 0) ? 32 : int'(v.len);
    mask   = (l == 32) ? 32'hFFFF_FFFF : ((32'h1 << l) - 32'h1);
    v.exp_miso = v.pre ? (v.tx & mask) : 32'h0;
    v.exp_rx   = v.mosi & mask;
    v.exp_und  = v.pre ? 0 : 1;
    return v;
  endfunction

  task automatic write_tx(input logic [31:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Master side of one word; got is rebuilt in the slave's word order.
  task automatic do_word(input logic [31:0] mosi, input int l, input int nsend,
                         input logic pol, input logic pha, input logic lf,
                         input int wr_at, input logic [31:0] wr_data,
                         output logic [31:0] got);
    logic b;
    got = '0;
    for (int i = 0; i < nsend; i++) begin
      if (i == wr_at) write_tx(wr_data);
      if (!pha) begin
        spi_in = lf ? mosi[i] : mosi[l-1-i];
        wait_cyc(H);
        b = spi_out;
        spi_clk = ~pol;
        wait_cyc(H);
        spi_clk = pol;
      end else begin
        spi_clk = ~pol;
        spi_in = lf ? mosi[i] : mosi[l-1-i];
        wait_cyc(H);
        b = spi_out;
        spi_clk = pol;
        wait_cyc(H);
      end
      if (lf) got[i] = b;
      else    got = {got[30:0], b};
    end
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lf, input logic [4:0] ln);
    cpol = pol; cpha = pha; lsb = lf; len = ln; spi_clk = pol;
    wait_cyc(4);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          l, r0, u0;
    logic [31:0] got;
    l = (v.len == 0) ? 32 : int'(v.len);
    set_mode(v.cpol, v.cpha, v.lsb, v.len);
    if (v.pre) begin
      write_tx(v.tx);
      check({tag, "_ready_low"}, tx_ready, 1'b0);
    end
    r0 = rx_cnt;
    u0 = und_cnt;
    spi_cs_n = 1'b0;
    wait_cyc(8);
    check({tag, "_tip"}, tip, 1'b1);
    check({tag, "_oe"}, spi_oe, 1'b1);
    check({tag, "_und_sel"}, und_cnt - u0, v.exp_und);
    do_word(v.mosi, l, l, v.cpol, v.cpha, v.lsb, -1, 32'h0, got);
    wait_cyc(4);
    spi_cs_n = 1'b1;
    wait_cyc(8);
    check({tag, "_miso"}, got, v.exp_miso);
    check({tag, "_rx_pulses"}, rx_cnt - r0, 1);
    check({tag, "_rx_word"}, last_rx(0), v.exp_rx);
    check({tag, "_rx_data"}, rx_data, v.exp_rx);
    check({tag, "_und_total"}, und_cnt - u0, v.exp_und + 1);
    check({tag, "_ready"}, tx_ready, 1'b1);
    check({tag, "_tip_off"}, tip, 1'b0);
    check({tag, "_miso_idle"}, spi_out, 1'b0);
  endtask

  initial begin
    int          r0, u0;
    logic [31:0] g1, g2;
    spi_cs_n = 1'b1; spi_clk = 1'b0; spi_in = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; len = 5'd8;
    rst = 1'b1;
    wait_cyc(3);
    check("rst_tip", tip, 1'b0);
    check("rst_oe", spi_oe, 1'b0);
    check("rst_miso", spi_out, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 32'h0);
    rst = 1'b0;
    wait_cyc(2);

    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd8,  1'b1, 32'hA5,       32'h3C,       32'hA5,       32'h3C,       0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd0,  1'b1, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 5'd16, 1'b0, 32'h0,        32'h1234,     32'h0,        32'h1234,     1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd12, 1'b1, 32'hABC,      32'h5A5,      32'hABC,      32'h5A5,      0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 32'hFFF3,     32'hFF0B,     32'h13,       32'h0B,       0};
    for (int i = 5; i < 11; i++) vecs[i] = mk_rand();
    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Deselect after 5 of 8 bits, with a word written mid-way.
    set_mode(1'b0, 1'b0, 1'b0, 5'd8);
    r0 = rx_cnt;
    spi_cs_n = 1'b0;
    wait_cyc(8);
    do_word(32'hF0, 8, 5, 1'b0, 1'b0, 1'b0, 2, 32'h96, g1);
    spi_cs_n = 1'b1;
    wait_cyc(8);
    check("abort_rx_pulses", rx_cnt - r0, 0);
    check("abort_hold_kept", tx_ready, 1'b0);
    check("abort_tip", tip, 1'b0);
    run_vec('{1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 32'h0, 32'h69, 32'h96, 32'h69, 0}, "after_abort");

    // Two back-to-back words, second tx word written during the first.
    set_mode(1'b0, 1'b0, 1'b0, 5'd8);
    write_tx(32'h11);
    r0 = rx_cnt;
    u0 = und_cnt;
    spi_cs_n = 1'b0;
    wait_cyc(8);
    do_word(32'hC3, 8, 8, 1'b0, 1'b0, 1'b0, 3, 32'h22, g1);
    check("b2b_und_mid", und_cnt - u0, 0);
    do_word(32'h7E, 8, 8, 1'b0, 1'b0, 1'b0, -1, 32'h0, g2);
    wait_cyc(4);
    spi_cs_n = 1'b1;
    wait_cyc(8);
    check("b2b_miso1", g1, 32'h11);
    check("b2b_miso2", g2, 32'h22);
    check("b2b_rx_pulses", rx_cnt - r0, 2);
    check("b2b_rx1", last_rx(1), 32'hC3);
    check("b2b_rx2", last_rx(0), 32'h7E);
    check("b2b_und_total", und_cnt - u0, 1);

    // Reset in the middle of a word with the holding register full.
    set_mode(1'b0, 1'b0, 1'b0, 5'd8);
    write_tx(32'h5A);
    spi_cs_n = 1'b0;
    wait_cyc(8);
    do_word(32'hB4, 8, 4, 1'b0, 1'b0, 1'b0, 2, 32'h77, g1);
    check("pre_rst_ready", tx_ready, 1'b0);
    r0 = rx_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_tip", tip, 1'b0);
    check("mid_rst_oe", spi_oe, 1'b0);
    check("mid_rst_miso", spi_out, 1'b0);
    check("mid_rst_ready", tx_ready, 1'b1);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_underrun", underrun, 1'b0);
    check("mid_rst_rx_data", rx_data, 32'h0);
    spi_cs_n = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);
    check("post_rst_rx_pulses", rx_cnt - r0, 0);
    check("post_rst_tip", tip, 1'b0);
    run_vec('{1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 32'hC7, 32'h35, 32'hC7, 32'h35, 0}, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
